bank_writer64: RTL and testbench
================================

# bank_writer64

Loads a stream of words into a 64-entry register bank through a valid/ready handshake. A 6-bit write pointer is decoded to a one-hot write enable, and each accepted word is stored at that index. The bank outputs drive the d0..d63 inputs of the 64:1 word selector, whose `count` select is the read side. This block is the writer end of that bank: it fills the bank and signals when the read side may begin.

## Interface
- Clock `clk` is a single clock. Reset `reset` is synchronous and active-high.
- Parameters:
  - `WIDTH`, default 32: bits per stored word.
  - `NWORDS`, default 64: number of words per load. Legal range 1..64.
- Ports:
  - `clk` in 1: clock; all state updates on its rising edge.
  - `reset` in 1: synchronous, active-high; overrides every other input.
  - `start` in 1: begins a load. Honoured only in IDLE.
  - `abort` in 1: ends a load early. Honoured only in LOAD.
  - `in_valid` in 1: `in_data` holds a word.
  - `in_data` in WIDTH: word to store.
  - `in_ready` out 1: block will accept a word this cycle.
  - `wr_index` out 6: current write pointer.
  - `busy` out 1: high in LOAD.
  - `done` out 1: one-cycle pulse when a load completes normally.
  - `q` out WIDTH x 64: unpacked bank contents `q[0:63]`, registered.

## Operation
- States: IDLE, LOAD, DONE.
- IDLE:
  - `in_ready`=0, `busy`=0.
  - `start`=1 → LOAD with `wr_index`←0.
- LOAD:
  - `in_ready`=1, `busy`=1.
  - Transfer occurs when `in_valid` & `in_ready` at the clock edge. Then `q[wr_index]`←`in_data` and `wr_index`←`wr_index`+1.
  - Transfer with `wr_index`==NWORDS-1 → DONE, and `wr_index` wraps to 0 (6-bit modulo for NWORDS=64).
  - `abort`=1 → IDLE. Any transfer in that same cycle is discarded. `q` keeps words already written; `wr_index` is held.
  - `abort` takes priority over completion.
- DONE: `done`=1 for exactly one cycle, then IDLE unconditionally. `start` in DONE is ignored.
- Entries at or above NWORDS are never written.
- Only one entry is written per cycle, selected by the one-hot decode of `wr_index`.
- `start` is ignored in LOAD. `in_valid` is ignored outside LOAD; no data is dropped silently, since `in_ready`=0 there.
- Reset values:
  - state IDLE, `wr_index`=0, `in_ready`=0, `busy`=0, `done`=0.
  - all `q[i]`=0.
- Reset mid-load: the load is abandoned and the bank is cleared to 0 on that edge.

## Timing
- `in_ready`, `busy`, `done` and `wr_index` are decoded from registered state; there is no combinational path from inputs to outputs.
- Write latency: a word accepted at edge N appears on `q[idx]` after edge N.
- First transfer is possible on the edge after the `start` edge.
- A full load with back-to-back `in_valid` takes 1 + NWORDS + 1 cycles from `start` to `done` high.
- `done` is high during the cycle after the final transfer edge.
- Back-to-back loads: the next `start` is accepted in the cycle after `done`.
- `q` is stable whenever `busy`=0. The read side samples only then.

## Configuration
- Macro: `BANK_WRITER64_CLEAR_EN`.
- Defined: on the edge that accepts `start` (IDLE→LOAD), all 64 `q` entries are cleared to 0. Entries not rewritten during the load read 0.
- Undefined: `start` leaves `q` untouched. Stale words remain in entries not rewritten, e.g. entries NWORDS..63 or entries after an abort.

## Structure
- Shared package `bank_pkg` holds:
  - `DEPTH`=64
  - `IDXW`=6
  - `typedef enum logic [1:0] {IDLE, LOAD, DONE} bank_state_t`
- The package is also imported by the read-side wrapper.
- One sub-module, `dec6to64`: 6-bit index plus enable in, 64-bit one-hot write enable out (all-zero when enable=0).
- The bank is 64 enabled registers in a generate loop, each gated by its one-hot bit.

## Test plan
- Full load, NWORDS=64: reset, `start`, stream `in_data`=i+0x100 with `in_valid` held high. Expect `q[i]`=0x100+i for all i, `done` high exactly one cycle at cycle 66 after `start`, then `wr_index`=0.
- Backpressure gaps: toggle `in_valid` 1,0,1,0 during the load. Expect `wr_index` to advance only on valid edges and no duplicate or skipped writes.
- Abort: load 0xAAAA0000..0xAAAA0009, then assert `abort` with `in_valid`=1 and data 0xDEAD. Expect IDLE, `q[0..9]` loaded, `q[10]` unchanged (0xDEAD not written), no `done`.
- NWORDS=5 with `BANK_WRITER64_CLEAR_EN`: preload the bank with 0xFF, then load 1..5. Expect `q[0..4]`=1..5 and `q[5..63]`=0. Without the macro, expect `q[5..63]`=0xFF.
- Reset mid-load: assert `reset` after 20 transfers. Expect all `q`=0, IDLE, `in_ready`=0 on the next cycle, and any `start` during the reset cycle ignored.
- Ignored inputs: `start` during LOAD and `in_valid` during IDLE/DONE. Expect no state change and no write.

Source files
------------

// File: rtl/bank_pkg.sv
// Shared definitions for the 64-entry register bank.
// Imported by the writer (bank_writer64), its decoder and the read-side wrapper.
package bank_pkg;
    localparam int DEPTH = 64;
    localparam int IDXW  = 6;

    typedef enum logic [1:0] {IDLE, LOAD, DONE} bank_state_t;
endpackage

// File: rtl/dec6to64.sv
// 6-bit index to 64-bit one-hot write-enable decoder.
// The output is all-zero when en is low.
module dec6to64
    import bank_pkg::*;
(
    input  logic [IDXW-1:0]  idx,
    input  logic             en,
    output logic [DEPTH-1:0] onehot
);

    // One bit set at idx when enabled, otherwise nothing selected
    always_comb begin
        onehot = '0;
        if (en) onehot[idx] = 1'b1;
    end

endmodule

// File: rtl/bank_writer64.sv
// Writer end of the 64-entry register bank. It fills q[] through a
// valid/ready handshake and pulses done when a load completes.
// Optional feature macro: BANK_WRITER64_CLEAR_EN. When it is defined, accepting
// start clears the whole bank. When it is undefined, start leaves q untouched.
module bank_writer64
    import bank_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NWORDS = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic [IDXW-1:0]  wr_index,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q [0:DEPTH-1]
);

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NWORDS - 1);

    bank_state_t      state, state_nxt;
    logic             xfer;
    logic             commit;
    logic             last;
    logic             clr;
    logic [DEPTH-1:0] we;

    // A handshake in the same cycle as abort is dropped; abort wins over completion
    assign xfer   = (state == LOAD) && in_valid;
    assign commit = xfer && !abort;
    assign last   = commit && (wr_index == LAST_IDX);

`ifdef BANK_WRITER64_CLEAR_EN
    assign clr = (state == IDLE) && start;
`else
    assign clr = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD: begin
                if (abort)     state_nxt = IDLE;
                else if (last) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded only from registered state
    always_comb begin
        in_ready = (state == LOAD);
        busy     = (state == LOAD);
        done     = (state == DONE);
    end

    // Write pointer: zeroed on start, advances per accepted word, wraps after the last word
    always_ff @(posedge clk) begin
        if (reset)
            wr_index <= '0;
        else if ((state == IDLE) && start)
            wr_index <= '0;
        else if (commit)
            wr_index <= last ? '0 : wr_index + 1'b1;
    end

    // Guard on NWORDS keeps entries at or above the load size untouched
    dec6to64 u_dec (
        .idx    (wr_index),
        .en     (commit && (int'(wr_index) < NWORDS)),
        .onehot (we)
    );

    for (genvar i = 0; i < DEPTH; i++) begin : g_bank
        // Entry register: cleared by reset (or start when clear is enabled), loaded when selected
        always_ff @(posedge clk) begin
            if (reset || clr) q[i] <= '0;
            else if (we[i])   q[i] <= in_data;
        end
    end

endmodule

// File: tb/tb_bank_writer64.sv
// Randomized self-checking bench for bank_writer64. It drives a 64-word
// and a 5-word instance with shared stimulus and compares both against a
// behavioural model of the load protocol.
module tb_bank_writer64;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset, start, abort, in_valid;
    logic [W-1:0]  in_data;

    logic          rdy0, bsy0, dn0, rdy1, bsy1, dn1;
    logic [5:0]    wi0, wi1;
    logic [W-1:0]  q0 [0:63];
    logic [W-1:0]  q1 [0:63];

    int n_chk = 0;
    int n_err = 0;

    // Model state per instance: phase 0=idle 1=loading 2=done
    int            nw    [2] = '{64, 5};
    int            phase [2];
    int            ptr   [2];
    logic [W-1:0]  mq    [2][64];

    always #5 clk = ~clk;

    bank_writer64 #(.WIDTH(W), .NWORDS(64)) u0 (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .in_valid(in_valid), .in_data(in_data), .in_ready(rdy0),
        .wr_index(wi0), .busy(bsy0), .done(dn0), .q(q0)
    );

    bank_writer64 #(.WIDTH(W), .NWORDS(5)) u1 (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .in_valid(in_valid), .in_data(in_data), .in_ready(rdy1),
        .wr_index(wi1), .busy(bsy1), .done(dn1), .q(q1)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: apply one clock edge with the current inputs
    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                phase[k] = 0;
                ptr[k]   = 0;
                for (int i = 0; i < 64; i++) mq[k][i] = '0;
            end else if (phase[k] == 0) begin
                if (start) begin
                    phase[k] = 1;
                    ptr[k]   = 0;
`ifdef BANK_WRITER64_CLEAR_EN
                    for (int i = 0; i < 64; i++) mq[k][i] = '0;
`endif
                end
            end else if (phase[k] == 1) begin
                if (abort) phase[k] = 0;
                else if (in_valid) begin
                    mq[k][ptr[k]] = in_data;
                    if (ptr[k] == nw[k] - 1) begin
                        ptr[k]   = 0;
                        phase[k] = 2;
                    end else ptr[k]++;
                end
            end else phase[k] = 0;
        end
    endtask

    task automatic check_all();
        chk("u0.in_ready", 64'(rdy0), 64'(phase[0] == 1));
        chk("u0.busy",     64'(bsy0), 64'(phase[0] == 1));
        chk("u0.done",     64'(dn0),  64'(phase[0] == 2));
        chk("u0.wr_index", 64'(wi0),  64'(ptr[0]));
        chk("u1.in_ready", 64'(rdy1), 64'(phase[1] == 1));
        chk("u1.busy",     64'(bsy1), 64'(phase[1] == 1));
        chk("u1.done",     64'(dn1),  64'(phase[1] == 2));
        chk("u1.wr_index", 64'(wi1),  64'(ptr[1]));
        for (int i = 0; i < 64; i++) begin
            chk($sformatf("u0.q[%0d]", i), 64'(q0[i]), 64'(mq[0][i]));
            chk($sformatf("u1.q[%0d]", i), 64'(q1[i]), 64'(mq[1][i]));
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic drive(input logic r, input logic s, input logic a,
                         input logic v, input logic [W-1:0] d);
        reset = r; start = s; abort = a; in_valid = v; in_data = d;
    endtask

    // Leave both instances idle regardless of where random stimulus left them
    task automatic settle();
        drive(0, 0, 1, 0, '0); cyc();
        drive(0, 0, 0, 0, '0); cyc(); cyc();
    endtask

    initial begin
        drive(1, 1, 0, 1, 32'h1234);
        cyc(); cyc();
        drive(0, 0, 0, 0, '0);
        cyc();
        chk("reset_busy", 64'(bsy0), 64'd0);
        chk("reset_q63",  64'(q0[63]), 64'd0);

        // Full back-to-back load with stray start pulses mid-load
        drive(0, 1, 0, 0, '0); cyc();
        for (int i = 0; i < 64; i++) begin
            drive(0, (i >= 30 && i < 33), 0, 1, W'(32'h100 + i));
            cyc();
        end
        chk("done_at_66", 64'(dn0), 64'd1);
        chk("q5_full",    64'(q0[5]), 64'h105);
        drive(0, 0, 0, 1, 32'h5555); cyc();
        chk("done_one_cycle", 64'(dn0), 64'd0);
        chk("wrap_index",     64'(wi0), 64'd0);

        // Backpressure gaps: valid toggles every cycle
        drive(0, 1, 0, 0, '0); cyc();
        for (int i = 0; i < 40; i++) begin
            drive(0, 0, 0, i[0] == 1'b0, W'(32'h200 + i));
            cyc();
        end
        settle();

        // Abort with a concurrent handshake
        drive(0, 1, 0, 0, '0); cyc();
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 0, 1, W'(32'hAAAA0000 + i));
            cyc();
        end
        drive(0, 0, 1, 1, 32'hDEAD); cyc();
        chk("abort_idle", 64'(bsy0), 64'd0);
        chk("abort_q9",   64'(q0[9]), 64'hAAAA0009);
        chk("abort_no_dead", 64'(q0[10] == 32'hDEAD), 64'd0);
        drive(0, 0, 0, 1, 32'hBEEF); cyc();
        chk("abort_no_done", 64'(dn0), 64'd0);

        // Reset after 20 transfers, start held during the reset cycle
        drive(0, 1, 0, 0, '0); cyc();
        for (int i = 0; i < 20; i++) begin
            drive(0, 0, 0, 1, W'($urandom));
            cyc();
        end
        drive(1, 1, 0, 1, 32'h77); cyc();
        drive(0, 0, 0, 1, 32'h78); cyc();
        chk("rst_mid_ready", 64'(rdy0), 64'd0);
        chk("rst_mid_q0",    64'(q0[0]), 64'd0);

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            drive(($urandom % 400) == 0, ($urandom % 6) == 0, ($urandom % 50) == 0,
                  $urandom % 2, W'($urandom));
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
